// File: rtl/fifo_push_arbiter_if.sv
// Requester-side handshake and FIFO push signals shared by fifo_push_arbiter
// and whatever drives it (requesters plus the FIFO full flag).
`timescale 1ns/1ps
interface fifo_push_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
);
  localparam int OWNER_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]        req_i;
  logic [NUM_REQ*DATA_W-1:0] data_i;
  logic [NUM_REQ-1:0]        gnt_o;
  logic                      fifo_full_i;
  logic                      fifo_push_o;
  logic [DATA_W-1:0]         fifo_push_data_o;
  logic [OWNER_W-1:0]        owner_o;
  logic                      busy_o;

  // The master side is the requester/FIFO environment, the slave side is the arbiter.
  modport master (
    output req_i, data_i, fifo_full_i,
    input  gnt_o, fifo_push_o, fifo_push_data_o, owner_o, busy_o
  );

  modport slave (
    input  req_i, data_i, fifo_full_i,
    output gnt_o, fifo_push_o, fifo_push_data_o, owner_o, busy_o
  );
endinterface

// File: rtl/fifo_push_arbiter.sv
// Round-robin burst arbiter sharing one FIFO push port among NUM_REQ requesters.
// A grant lasts up to BURST_LEN beats; a one-cycle IDLE bubble separates bursts.
`timescale 1ns/1ps
module fifo_push_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int BURST_LEN = 4
) (
  input logic               clk,
  input logic               reset,
  fifo_push_arbiter_if.slave bus
);
  localparam int OWNER_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W   = (BURST_LEN + 1 > 1) ? $clog2(BURST_LEN + 1) : 1;
  localparam logic [CNT_W-1:0]   LAST_BEAT = CNT_W'(BURST_LEN - 1);
  localparam logic [OWNER_W-1:0] LAST_REQ  = OWNER_W'(NUM_REQ - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t             state, state_next;
  logic [OWNER_W-1:0] owner, owner_next;
  logic [OWNER_W-1:0] rr_ptr, rr_next;
  logic [CNT_W-1:0]   beat_cnt, cnt_next;

  logic               scan_hit;
  logic [OWNER_W-1:0] scan_idx;
  logic [OWNER_W-1:0] scan_cand;
  int                 scan_pos;
  logic               owner_req;
  logic               accept;
  logic [OWNER_W-1:0] owner_inc;

  // Priority scan starting at rr_ptr and wrapping at NUM_REQ-1; first set request wins.
  always_comb begin
    scan_hit  = 1'b0;
    scan_idx  = '0;
    scan_cand = '0;
    scan_pos  = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan_pos = int'(rr_ptr) + i;
      if (scan_pos >= NUM_REQ) begin
        scan_pos = scan_pos - NUM_REQ;
      end
      scan_cand = OWNER_W'(scan_pos);
      if (!scan_hit && bus.req_i[scan_cand]) begin
        scan_hit = 1'b1;
        scan_idx = scan_cand;
      end
    end
  end

  assign owner_inc = (owner == LAST_REQ) ? '0 : owner + 1'b1;

  always_comb begin
    state_next           = state;
    owner_next           = owner;
    rr_next              = rr_ptr;
    cnt_next             = beat_cnt;
    owner_req            = bus.req_i[owner];
    accept               = 1'b0;
    bus.gnt_o            = '0;
    bus.fifo_push_o      = 1'b0;
    bus.fifo_push_data_o = '0;
    bus.busy_o           = 1'b0;
    bus.owner_o          = owner;

    unique case (state)
      IDLE: begin
        if (scan_hit) begin
          owner_next = scan_idx;
          cnt_next   = '0;
          state_next = BURST;
        end
      end

      BURST: begin
        accept               = owner_req & ~bus.fifo_full_i;
        bus.busy_o           = 1'b1;
        bus.fifo_push_o      = accept;
        bus.gnt_o            = accept ? (NUM_REQ'(1) << owner) : '0;
        bus.fifo_push_data_o = accept ? bus.data_i[owner*DATA_W +: DATA_W] : '0;

        // Dropping the request ends the burst even while the FIFO is full.
        if (!owner_req) begin
          state_next = IDLE;
          rr_next    = owner_inc;
        end else if (accept) begin
          if (beat_cnt == LAST_BEAT) begin
            state_next = IDLE;
            rr_next    = owner_inc;
          end else begin
            cnt_next = beat_cnt + 1'b1;
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Reset abandons any burst at once; state decoding then forces all outputs low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      owner    <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_next;
      owner    <= owner_next;
      rr_ptr   <= rr_next;
      beat_cnt <= cnt_next;
    end
  end
endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Directed bench for fifo_push_arbiter: expected pushes are queued by the stimulus
// and popped by an independent negedge monitor whenever the arbiter pushes.
`timescale 1ns/1ps
module tb_fifo_push_arbiter;
  localparam int NUM_REQ   = 4;
  localparam int DATA_W    = 8;
  localparam int BURST_LEN = 4;

  typedef struct packed {
    logic [1:0] owner;
    logic [7:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic reset;

  int   assert_count = 0;
  int   fail_count   = 0;
  int   push_count   = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  logic [3:0] mon_gnt;
  logic [7:0] data_val [NUM_REQ];
  logic [3:0] last_gnt;
  int   push_base;

  always #5 clk = ~clk;

  fifo_push_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();

  fifo_push_arbiter #(
    .NUM_REQ(NUM_REQ),
    .DATA_W(DATA_W),
    .BURST_LEN(BURST_LEN)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assert_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] req, input logic full);
    bus.req_i       = req;
    bus.fifo_full_i = full;
  endtask

  task automatic driveData();
    for (int r = 0; r < NUM_REQ; r++) begin
      bus.data_i[r*DATA_W +: DATA_W] = data_val[r];
    end
  endtask

  task automatic expectPush(input logic [1:0] own, input logic [7:0] data);
    exp_q.push_back('{owner: own, data: data});
  endtask

  // Requesters advance their data only after a beat has been accepted.
  task automatic cycle();
    @(negedge clk);
    last_gnt = bus.gnt_o;
    @(posedge clk);
    #1;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (last_gnt[r]) data_val[r] = data_val[r] + 8'd1;
    end
    driveData();
  endtask

  task automatic expectState(input string tag, input logic busy, input logic [1:0] own,
                             input logic [3:0] gnt, input logic push);
    #1;
    checkOutput({tag, " busy"}, 32'(bus.busy_o), 32'(busy));
    checkOutput({tag, " gnt"},  32'(bus.gnt_o), 32'(gnt));
    checkOutput({tag, " push"}, 32'(bus.fifo_push_o), 32'(push));
    if (busy) checkOutput({tag, " owner"}, 32'(bus.owner_o), 32'(own));
    if (!push) checkOutput({tag, " pdata"}, 32'(bus.fifo_push_data_o), 32'd0);
  endtask

  task automatic doReset(input logic [3:0] req, input int cycles);
    @(negedge clk);
    #1;
    reset = 1'b0;
    applyStimulus(req, 1'b0);
    for (int c = 0; c < cycles; c++) begin
      expectState("reset", 1'b0, 2'd0, 4'b0000, 1'b0);
      checkOutput("reset owner", 32'(bus.owner_o), 32'd0);
      cycle();
    end
    reset = 1'b1;
  endtask

  // Scoreboard monitor: every push must match the head of the expected queue.
  always @(negedge clk) begin
    if (bus.fifo_push_o) begin
      push_count++;
      checkOutput("push while full", 32'(bus.fifo_full_i), 32'd0);
      if (exp_q.size() == 0) begin
        assert_count++;
        fail_count++;
        $display("[TB] FAIL unexpected push: got data %0h owner %0d, expected no push", bus.fifo_push_data_o, bus.owner_o);
      end else begin
        mon_e   = exp_q.pop_front();
        mon_gnt = 4'b0001 << mon_e.owner;
        checkOutput("sb data",  32'(bus.fifo_push_data_o), 32'(mon_e.data));
        checkOutput("sb owner", 32'(bus.owner_o), 32'(mon_e.owner));
        checkOutput("sb gnt",   32'(bus.gnt_o), 32'(mon_gnt));
      end
    end else if (bus.gnt_o != 4'b0000) begin
      checkOutput("gnt without push", 32'(bus.gnt_o), 32'd0);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b0;
    for (int r = 0; r < NUM_REQ; r++) data_val[r] = 8'h00;
    applyStimulus(4'b0000, 1'b0);
    driveData();

    // Reset with all requests high, then first grant goes to requester 0.
    for (int r = 0; r < NUM_REQ; r++) data_val[r] = 8'(8'hA0 + r);
    driveData();
    doReset(4'b1111, 3);
    expectState("t1 idle", 1'b0, 2'd0, 4'b0000, 1'b0);
    cycle();
    expectPush(2'd0, 8'hA0);
    expectState("t1 first", 1'b1, 2'd0, 4'b0001, 1'b1);

    // Single requester: four-beat burst, bubble, then a new burst by the same owner.
    doReset(4'b0000, 2);
    data_val[2] = 8'h10;
    driveData();
    applyStimulus(4'b0100, 1'b0);
    for (int i = 0; i < 5; i++) expectPush(2'd2, 8'(8'h10 + i));
    expectState("t2 bubble0", 1'b0, 2'd0, 4'b0000, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      cycle();
      expectState("t2 beat", 1'b1, 2'd2, 4'b0100, 1'b1);
    end
    cycle();
    expectState("t2 idle", 1'b0, 2'd0, 4'b0000, 1'b0);
    cycle();
    expectState("t2 next", 1'b1, 2'd2, 4'b0100, 1'b1);

    // Round-robin rotation 0,1,2,3,0 with all requesters active.
    doReset(4'b0000, 2);
    for (int r = 0; r < NUM_REQ; r++) data_val[r] = 8'(32 * (r + 1));
    driveData();
    applyStimulus(4'b1111, 1'b0);
    for (int b = 0; b < 5; b++) begin
      for (int j = 0; j < 4; j++) begin
        expectPush(2'(b % 4), 8'(32 * ((b % 4) + 1) + (b / 4) * 4 + j));
      end
    end
    for (int k = 0; k < 25; k++) begin
      if (k > 0) cycle();
      if (k % 5 == 0) begin
        expectState("t3 idle", 1'b0, 2'd0, 4'b0000, 1'b0);
      end else begin
        expectState("t3 beat", 1'b1, 2'(((k - 1) / 5) % 4), 4'(4'b0001 << (((k - 1) / 5) % 4)), 1'b1);
      end
    end

    // Back-pressure: FIFO full for three cycles after beat 2 of requester 1.
    doReset(4'b0000, 2);
    push_base = push_count;
    data_val[1] = 8'h50;
    driveData();
    applyStimulus(4'b0010, 1'b0);
    for (int i = 0; i < 4; i++) expectPush(2'd1, 8'(8'h50 + i));
    for (int k = 0; k <= 8; k++) begin
      if (k > 0) cycle();
      applyStimulus((k == 8) ? 4'b0000 : 4'b0010, (k >= 3 && k <= 5));
      if (k == 0 || k == 8) expectState("t4 idle", 1'b0, 2'd1, 4'b0000, 1'b0);
      else if (k >= 3 && k <= 5) expectState("t4 stall", 1'b1, 2'd1, 4'b0000, 1'b0);
      else expectState("t4 beat", 1'b1, 2'd1, 4'b0010, 1'b1);
    end
    checkOutput("t4 push total", 32'(push_count - push_base), 32'd4);

    // Early release by requester 3; rr_ptr wraps so requester 0 is next.
    doReset(4'b0000, 2);
    data_val[3] = 8'h70;
    data_val[0] = 8'h30;
    driveData();
    applyStimulus(4'b1000, 1'b0);
    expectPush(2'd3, 8'h70);
    expectPush(2'd3, 8'h71);
    expectPush(2'd0, 8'h30);
    expectState("t5 idle0", 1'b0, 2'd0, 4'b0000, 1'b0);
    cycle();
    applyStimulus(4'b1001, 1'b0);
    expectState("t5 beat1", 1'b1, 2'd3, 4'b1000, 1'b1);
    cycle();
    expectState("t5 beat2", 1'b1, 2'd3, 4'b1000, 1'b1);
    cycle();
    applyStimulus(4'b0001, 1'b0);
    expectState("t5 release", 1'b1, 2'd3, 4'b0000, 1'b0);
    cycle();
    expectState("t5 idle", 1'b0, 2'd0, 4'b0000, 1'b0);
    cycle();
    expectState("t5 owner0", 1'b1, 2'd0, 4'b0001, 1'b1);

    // Asynchronous reset in the middle of beat 2 of requester 2.
    doReset(4'b0000, 2);
    data_val[2] = 8'h90;
    data_val[1] = 8'hB0;
    driveData();
    applyStimulus(4'b0100, 1'b0);
    expectPush(2'd2, 8'h90);
    expectState("t6 idle0", 1'b0, 2'd0, 4'b0000, 1'b0);
    cycle();
    expectState("t6 beat1", 1'b1, 2'd2, 4'b0100, 1'b1);
    cycle();
    expectState("t6 beat2", 1'b1, 2'd2, 4'b0100, 1'b1);
    #1;
    reset = 1'b0;
    expectState("t6 async", 1'b0, 2'd0, 4'b0000, 1'b0);
    applyStimulus(4'b0110, 1'b0);
    cycle();
    reset = 1'b1;
    expectPush(2'd1, 8'hB0);
    expectState("t6 idle", 1'b0, 2'd0, 4'b0000, 1'b0);
    cycle();
    expectState("t6 owner1", 1'b1, 2'd1, 4'b0010, 1'b1);

    doReset(4'b0000, 1);
    checkOutput("sb leftover", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end
endmodule

// File: doc/fifo_push_arbiter.md
Name: fifo_push_arbiter

Overview:
- Round-robin write-side arbiter that shares one synchronous FIFO's push port among NUM_REQ requesters.
- Grants one requester at a time for a burst of up to BURST_LEN beats.
- Forwards the granted requester's data to the FIFO and back-pressures on FIFO full.
- Sits directly in front of the FIFO and drives its push strobe and push data.

Parameters:
NUM_REQ, 4, number of requesters (>=2)
DATA_W, 8, data width per beat
BURST_LEN, 4, max beats per grant (>=1)

Ports:
clk  input  1  clock
reset  input  1  one clock; reset is asynchronous and active-low (asserted when 0)
req_i  input  NUM_REQ  per-requester request; requester holds data valid while high
data_i  input  NUM_REQ*DATA_W  requester r data in bits [r*DATA_W +: DATA_W]
gnt_o  output  NUM_REQ  one-hot accept strobe; bit r high means requester r's beat is consumed this cycle
fifo_full_i  input  1  FIFO full flag
fifo_push_o  output  1  FIFO push strobe
fifo_push_data_o  output  DATA_W  FIFO push data
owner_o  output  $clog2(NUM_REQ)  index of current burst owner (valid when busy_o)
busy_o  output  1  high in BURST state

Behaviour:
- State: IDLE, BURST.
- Registers: owner, rr_ptr, beat_cnt ($clog2(BURST_LEN+1) bits).
- Reset (reset=0, async):
  - state=IDLE, rr_ptr=0, owner=0, beat_cnt=0.
  - All outputs 0; fifo_push_data_o=0.
- Reset asserted mid-burst: burst is abandoned immediately and no push is issued; after release, arbitration restarts from rr_ptr=0.
- IDLE:
  - fifo_push_o=0, gnt_o=0.
  - If any req_i bit is set, owner <= first set bit scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ; beat_cnt <= 0; state <= BURST.
  - One-cycle arbitration bubble; no beat is accepted in IDLE.
- BURST, combinational outputs:
  - accept = req_i[owner] & ~fifo_full_i.
  - fifo_push_o = accept; gnt_o = accept ? (1<<owner) : 0.
  - fifo_push_data_o = data_i slice of owner when accept, else 0.
  - busy_o=1, owner_o=owner.
- BURST, sequential:
  - accept and beat_cnt==BURST_LEN-1: burst ends; state <= IDLE, rr_ptr <= (owner+1) mod NUM_REQ.
  - accept otherwise: beat_cnt <= beat_cnt+1.
  - req_i[owner]==0 (regardless of full): burst ends with no push; state <= IDLE, rr_ptr <= (owner+1) mod NUM_REQ.
  - req_i[owner]==1 and fifo_full_i==1: stall; state, beat_cnt and owner unchanged; no push; no timeout.
- Non-owner requests are ignored during BURST and keep waiting; gnt_o stays 0 for them.
- Throughput: at most BURST_LEN beats per BURST_LEN+1 cycles with no stalls.
- Fairness: a continuously requesting requester is granted within NUM_REQ-1 intervening bursts.
- BURST_LEN=1: every beat is its own burst, alternating IDLE/BURST.
- Wrap-around: rr_ptr, and the priority scan from rr_ptr, wrap from NUM_REQ-1 to 0.
- fifo_push_o is never asserted while fifo_full_i=1. FIFO overflow is impossible by construction, provided fifo_full_i is accurate in the cycle it is sampled.

Test Plan:
- Reset then idle: reset=0 for 3 cycles with req_i=4'b1111 -> all outputs 0; after release, first cycle IDLE, next cycle owner_o=0, gnt_o=4'b0001, fifo_push_o=1.
- Single requester full burst: req_i=4'b0100 held, data_i[2] = 0x10,0x11,0x12,0x13,0x14 per accepted beat, full=0 -> pushes 0x10..0x13 on 4 consecutive cycles with gnt_o=4'b0100, 1 IDLE cycle, then 0x14 starts a new burst with owner 2.
- Round-robin rotation: req_i=4'b1111 held, full=0 -> bursts of 4 beats with owners 0,1,2,3,0, each separated by one IDLE cycle.
- Back-pressure: requester 1 in burst, assert fifo_full_i for 3 cycles after beat 2 -> no push and gnt_o=0 for 3 cycles, beat_cnt held; beats 3 and 4 follow when full drops; 4 total pushes.
- Early release: requester 3 drops req_i after 2 beats, req_i[0] high -> burst ends with no push that cycle; IDLE; next owner 0 (rr_ptr wrapped from 3 to 0).
- Async reset mid-burst: reset=0 asynchronously mid-beat-2 of owner 2 -> fifo_push_o and gnt_o drop without a clock edge; after release, with req_i=4'b0110, owner is 1.
